// File: rtl/case_lut_pkg.sv
// Shared definitions for the programmable lookup table.
package case_lut_pkg;

  localparam int DEF_KEY_W = 2;
  localparam int DEF_VAL_W = 2;
  localparam int DEF_CNT_W = 8;

  // Saturation value of a hit counter of the default width.
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

  // One table entry at the default widths.
  typedef struct packed {
    logic                 vld;
    logic [DEF_KEY_W-1:0] key;
    logic [DEF_VAL_W-1:0] val;
  } entry_t;

  // Index width for n entries; a single-entry table still needs one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lut_prio_match.sv
// Combinational lowest-index-first match over the table entries.
module lut_prio_match #(
  parameter int KEY_W   = 2,
  parameter int VAL_W   = 2,
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0] vld,
  input  logic [KEY_W-1:0]   keys [ENTRIES],
  input  logic [VAL_W-1:0]   vals [ENTRIES],
  input  logic [KEY_W-1:0]   lk_key,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [VAL_W-1:0]   val
);

  // First valid matching entry wins; later duplicates are shadowed.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    val = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && vld[i] && keys[i] == lk_key) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        val = vals[i];
      end
    end
  end

endmodule

// File: rtl/case_lut_reg.sv
// Programmable registered lookup table with priority match and hit counter.
module case_lut_reg
  import case_lut_pkg::*;
#(
  parameter int              KEY_W       = 2,
  parameter int              VAL_W       = 2,
  parameter int              ENTRIES     = 4,
  parameter logic [VAL_W-1:0] DEFAULT_VAL = '0,
  parameter int              CNT_W       = 8,
  localparam int             IDX_W       = clog2_min1(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             wr_vld,
  input  logic             lk_valid,
  input  logic [KEY_W-1:0] lk_key,
  output logic             out_valid,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx,
  output logic [VAL_W-1:0] out_val,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRIES-1:0] ent_vld;
  logic [KEY_W-1:0]   ent_key [ENTRIES];
  logic [VAL_W-1:0]   ent_val [ENTRIES];

  logic               m_hit;
  logic [IDX_W-1:0]   m_idx;
  logic [VAL_W-1:0]   m_val;

  lut_prio_match #(
    .KEY_W   (KEY_W),
    .VAL_W   (VAL_W),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_match (
    .vld    (ent_vld),
    .keys   (ent_key),
    .vals   (ent_val),
    .lk_key (lk_key),
    .hit    (m_hit),
    .idx    (m_idx),
    .val    (m_val)
  );

  // Entry storage: clear beats write; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_key[i] <= '0;
        ent_val[i] <= '0;
      end
    end else if (clr) begin
      ent_vld <= '0;
    end else if (wr_en && int'(wr_idx) < ENTRIES) begin
      ent_vld[wr_idx] <= wr_vld;
      ent_key[wr_idx] <= wr_key;
      ent_val[wr_idx] <= wr_val;
    end
  end

  // Output stage: match result of the pre-edge table, held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      out_val   <= DEFAULT_VAL;
    end else begin
      out_valid <= lk_valid;
      if (lk_valid) begin
        out_hit <= m_hit;
        out_idx <= m_hit ? m_idx : '0;
        out_val <= m_hit ? m_val : DEFAULT_VAL;
      end
    end
  end

  // Saturating hit counter, zeroed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clr) begin
      hit_count <= '0;
    end else if (lk_valid && m_hit && hit_count != CNT_MAX) begin
      hit_count <= hit_count + 1'b1;
    end
  end

endmodule
